// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: one op at a time over valid/ready, registered 2*DATA_WIDTH result.
// Define ALU_SEQ_DIV_EN to build the sequential signed divider (op 6); otherwise op 6 is illegal.
module alu_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4:0]              req_op,
  input  logic [DATA_WIDTH-1:0]   req_a,
  input  logic [DATA_WIDTH-1:0]   req_b,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [4:0]              alu_op,
  input  logic [2*DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0]   z_hi,
  output logic [DATA_WIDTH-1:0]   z_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    illegal_op,
  output logic                    div_by_zero,
  output logic                    busy
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [4:0] OP_MUL = 5'd5;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [4:0]      op_q;
  logic [DW-1:0]   a_q, b_q;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign req_ready = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

`ifdef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_DIV = 5'd6;

  logic [DW-1:0] rem_q, quo_q, dvs_q, rem_sh;
  logic [CW-1:0] cnt_q;
  logic          dbz_q, take;

  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

  // rem < |b| <= 2^(DW-1), so the shifted partial remainder never overflows DW bits
  assign rem_sh      = {rem_q[DW-2:0], quo_q[DW-1]};
  assign take        = (rem_sh >= dvs_q);
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z_hi       <= '0;
      z_lo       <= '0;
      illegal_op <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      dbz_q      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q       <= req_op;
          a_q        <= req_a;
          b_q        <= req_b;
          illegal_op <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
          dbz_q      <= 1'b0;
`endif
          if (req_op <= OP_MUL) begin
            state <= S_EXEC;
`ifdef ALU_SEQ_DIV_EN
          end else if (req_op == OP_DIV) begin
            rem_q <= '0;
            quo_q <= mag(req_a);
            dvs_q <= mag(req_b);
            cnt_q <= '0;
            state <= (req_b == '0) ? S_FIX : S_DIV;
`endif
          end else begin
            z_hi       <= '0;
            z_lo       <= '0;
            illegal_op <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_EXEC: begin
          {z_hi, z_lo} <= alu_result;
          state        <= S_DONE;
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          // quo_q shifts dividend bits out at the top and quotient bits in at the bottom
          rem_q <= take ? rem_sh - dvs_q : rem_sh;
          quo_q <= {quo_q[DW-2:0], take};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW-1)) state <= S_FIX;
        end
        S_FIX: begin
          if (b_q == '0) begin
            z_lo  <= '1;
            z_hi  <= a_q;
            dbz_q <= 1'b1;
          end else begin
            z_lo <= (a_q[DW-1] ^ b_q[DW-1]) ? -quo_q : quo_q;
            z_hi <= a_q[DW-1] ? -rem_q : rem_q;
          end
          state <= S_DONE;
        end
`endif
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus hand sequences for hold, reset-abort and DIV.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, out_valid, out_ready, illegal_op, div_by_zero, busy;
  logic [4:0]  req_op, alu_op;
  logic [31:0] req_a, req_b, alu_a, alu_b, z_hi, z_lo;
  logic [63:0] alu_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .z_hi(z_hi), .z_lo(z_lo), .out_valid(out_valid), .out_ready(out_ready),
    .illegal_op(illegal_op), .div_by_zero(div_by_zero), .busy(busy)
  );

  // Reference combinational ALU: signed ops sign-extend, ADDU carries into the high word
  always_comb begin
    alu_result = '0;
    case (alu_op)
      5'd0: alu_result = {32'h0, alu_a | alu_b};
      5'd1: alu_result = {32'h0, alu_a & alu_b};
      5'd2: alu_result = {{32{alu_a[31]}}, alu_a} + {{32{alu_b[31]}}, alu_b};
      5'd3: alu_result = {{32{alu_a[31]}}, alu_a} - {{32{alu_b[31]}}, alu_b};
      5'd4: alu_result = {32'h0, alu_a} + {32'h0, alu_b};
      5'd5: alu_result = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        ill, dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                              input logic ill, input logic dbz, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    v.ill = ill; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  // Issue one request; returns the cycle index (accept edge = N) at which out_valid was first seen
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_back_idle"}, {62'h0, req_ready, busy}, 64'h2);
  endtask

  initial begin
    int lat;
    logic [63:0] held;

    vecs.push_back(mk("add_5_7",   5'd2, 32'd5,        32'd7,        32'h0,        32'd12,       0, 0, 2));
    vecs.push_back(mk("or",        5'd0, 32'hF0F00000, 32'h00000F0F, 32'h0,        32'hF0F00F0F, 0, 0, 2));
    vecs.push_back(mk("and",       5'd1, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0F000F00, 0, 0, 2));
    vecs.push_back(mk("sub_neg",   5'd3, 32'd3,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 2));
    vecs.push_back(mk("addu_cy",   5'd4, 32'hFFFFFFFF, 32'd2,        32'h1,        32'h1,        0, 0, 2));
    vecs.push_back(mk("add_max",   5'd2, 32'h7FFFFFFF, 32'd1,        32'h0,        32'h80000000, 0, 0, 2));
    vecs.push_back(mk("mul_big",   5'd5, 32'h00010000, 32'h00010000, 32'h1,        32'h0,        0, 0, 2));
    vecs.push_back(mk("illegal20", 5'd20, 32'd9,       32'd9,        32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk("add_clr",   5'd2, 32'd1,        32'd1,        32'h0,        32'd2,        0, 0, 2));
    vecs.push_back(mk("illegal31", 5'd31, 32'hFFFFFFFF, 32'd1,       32'h0,        32'h0,        1, 0, 1));
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back(mk("div_m17_5",  5'd6, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 34));
    vecs.push_back(mk("div_ovf",    5'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 0, 0, 34));
    vecs.push_back(mk("div_100_m7", 5'd6, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 0, 0, 34));
    vecs.push_back(mk("div_by_0",   5'd6, 32'd42,       32'd0,        32'd42,       32'hFFFFFFFF, 0, 1, 2));
    vecs.push_back(mk("add_clr_dz", 5'd2, 32'd3,        32'd4,        32'h0,        32'd7,        0, 0, 2));
`else
    vecs.push_back(mk("div_m17_5",  5'd6, 32'hFFFFFFEF, 32'd5,        32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk("div_ovf",    5'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk("div_by_0",   5'd6, 32'd42,       32'd0,        32'h0,        32'h0,        1, 0, 1));
`endif

    // Reset with junk on the inputs
    rst_n = 1'b0; req_valid = 1'b1; req_op = 5'd2; req_a = 32'hDEAD; req_b = 32'hBEEF;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_outputs", {z_hi, z_lo}, 64'h0);
    chk("rst_status", {59'h0, out_valid, busy, illegal_op, div_by_zero, req_ready}, 64'h1);
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single-pass op: EXEC cycle shows busy and the operands on the ALU port
    req_valid = 1'b1; req_op = 5'd2; req_a = 32'd5; req_b = 32'd7;
    tick();
    req_valid = 1'b0;
    chk("exec_busy", {62'h0, busy, req_ready}, 64'h2);
    chk("exec_alu_drive", {alu_a, alu_b}, {32'd5, 32'd7});
    tick();
    chk("exec_done", {63'h0, out_valid}, 64'h1);
    chk("exec_z", {z_hi, z_lo}, 64'd12);
    handshake("exec");

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, "_z"}, {z_hi, z_lo}, {vecs[i].hi, vecs[i].lo});
      chk({vecs[i].name, "_flags"}, {62'h0, illegal_op, div_by_zero}, {62'h0, vecs[i].ill, vecs[i].dbz});
      handshake(vecs[i].name);
    end

    // MUL held in DONE for 5 cycles; a competing request must be ignored
    issue(5'd5, 32'hFFFFFFFD, 32'd4, lat);
    chk("mul_hold_lat", 64'(lat), 64'd2);
    held = 64'hFFFFFFFF_FFFFFFF4;
    req_valid = 1'b1; req_op = 5'd0; req_a = 32'h1234; req_b = 32'h5678;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("mul_hold_z%0d", c), {z_hi, z_lo}, held);
      chk($sformatf("mul_hold_hs%0d", c), {62'h0, out_valid, req_ready}, 64'h2);
      tick();
    end
    req_valid = 1'b0;
    handshake("mul_hold");

    // Reset during op 6 at cycle N+10 aborts it and discards the result
    req_valid = 1'b1; req_op = 5'd6; req_a = 32'hFFFFFFEF; req_b = 32'd5;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_z", {z_hi, z_lo}, 64'h0);
    chk("abort_status", {59'h0, out_valid, busy, illegal_op, div_by_zero, req_ready}, 64'h1);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) lat++;
      tick();
    end
    chk("abort_no_valid", 64'(lat), 64'd0);
    issue(5'd2, 32'd20, 32'd22, lat);
    chk("post_abort_lat", 64'(lat), 64'd2);
    chk("post_abort_z", {z_hi, z_lo}, 64'd42);
    handshake("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
